// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO consumer: pops a programmed number of words, checks them against
// an incrementing sequence, accumulates a checksum and applies optional backpressure.
module fifo_drain_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             yumi_o,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [WIDTH-1:0] base_i,
    input  logic [1:0]       stall_mode_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [WIDTH-1:0] checksum_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    localparam logic [7:0]       LFSR_SEED = 8'hA5;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DATA_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] expect_q;
    logic [7:0]       lfsr_q;
    logic             stall_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [WIDTH-1:0] checksum_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] word_cnt_inc;
    logic             xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Fibonacci LFSR, taps 8,6,5,4; a nonzero seed can never reach zero
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    assign yumi_o       = !reset && (state == DRAIN) && valid_i && !stall_q;
    assign xfer         = yumi_o;
    assign word_cnt_inc = word_cnt_q + CNT_ONE;

    assign busy_o     = (state == DRAIN);
    assign done_o     = (state == DONE);
    assign word_cnt_o = word_cnt_q;
    assign checksum_o = checksum_q;
    assign err_o      = err_q;
    assign err_cnt_o  = err_cnt_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = (count_i != '0) ? DRAIN : DONE;
            DRAIN:   if (xfer && (word_cnt_inc == count_q)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count_q    <= '0;
            mode_q     <= '0;
            expect_q   <= '0;
            lfsr_q     <= LFSR_SEED;
            stall_q    <= 1'b0;
            word_cnt_q <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start_i) begin
                count_q    <= count_i;
                mode_q     <= stall_mode_i;
                expect_q   <= base_i;
                lfsr_q     <= LFSR_SEED;
                stall_q    <= 1'b0;
                word_cnt_q <= '0;
                checksum_q <= '0;
                err_q      <= 1'b0;
                err_cnt_q  <= '0;
            end else if (state == DRAIN) begin
                if (xfer) begin
                    word_cnt_q <= word_cnt_inc;
                    checksum_q <= checksum_q + data_i;
                    expect_q   <= expect_q + DATA_ONE;
                    if (data_i != expect_q) begin
                        err_q     <= 1'b1;
                        err_cnt_q <= sat_inc(err_cnt_q);
                    end
                end
                // Backpressure is re-evaluated every DRAIN cycle, transfer or not
                case (mode_q)
                    2'd1: stall_q <= ~stall_q;
                    2'd2: begin
                        stall_q <= lfsr_q[0];
                        lfsr_q  <= lfsr_next(lfsr_q);
                    end
                    default: stall_q <= 1'b0;
                endcase
            end
        end
    end

endmodule
